// File: rtl/data_cache_port0_arbiter.sv
// Cache port 0 arbiter.
// Three requesters share data-cache port 0: external invalidate (0),
// store unit (1) and load unit (2). A grant persists until the owner
// releases it. After every release there is one dead cycle before the
// next owner is granted. Requesters that have waited STARVE_LIMIT cycles
// are promoted over the fixed priority order.
module data_cache_port0_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8  // legal range 1..255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inv_request_i,
  input  logic       stu_request_i,
  input  logic       ldu_request_i,
  input  logic [2:0] release_i,
  output logic [2:0] grant_o,
  output logic [1:0] port0_select_o,
  output logic       port0_busy_o,
  output logic [2:0] starved_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [2:0] grant_reg;
  logic [2:0] grant_next;
  logic [2:0] request;
  logic [2:0] starved;
  logic [2:0] starved_request;
  logic       owner_release;

  // Bit index of the request vector matches the requester index.
  assign request         = {ldu_request_i, stu_request_i, inv_request_i};
  assign starved_request = request & starved;
  assign owner_release   = |(release_i & grant_reg);

  // Isolate the lowest set bit. This gives fixed priority with index 0 highest.
  function automatic logic [2:0] lowest_set(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  // Next state and next grant. Promoted requesters take precedence in IDLE.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (|request) begin
          state_next = OWNED;
          if (|starved_request) begin
            grant_next = lowest_set(starved_request);
          end else begin
            grant_next = lowest_set(request);
          end
        end
      end
      OWNED: begin
        // Only the owner's release bit matters; the owner's request level is ignored.
        if (owner_release) begin
          state_next = IDLE;
          grant_next = 3'b000;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 3'b000;
      end
    endcase
  end

  // State and grant registers. Reset drops any grant immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= 3'b000;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
    end
  end

  // One saturating wait counter per requester.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : wait_g
      logic [7:0] count_reg;
      logic [7:0] count_next;

      // The count clears when the request drops, or when the requester holds the grant or wins it on this edge.
      always_comb begin
        count_next = count_reg;
        if (!request[gi] || grant_reg[gi] || grant_next[gi]) begin
          count_next = 8'd0;
        end else if (count_reg != LIMIT) begin
          count_next = count_reg + 8'd1;
        end
      end

      // Counter register, cleared asynchronously by reset.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          count_reg <= 8'd0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign starved[gi] = (count_reg == LIMIT);
    end
  endgenerate

  // Decode the port mux select from the registered grant.
  always_comb begin
    port0_select_o = 2'b00;
    case (grant_reg)
      3'b001:  port0_select_o = 2'b01;
      3'b010:  port0_select_o = 2'b10;
      3'b100:  port0_select_o = 2'b11;
      default: port0_select_o = 2'b00;
    endcase
  end

  assign grant_o      = grant_reg;
  assign port0_busy_o = |grant_reg;
  assign starved_o    = starved;

endmodule

// File: tb/tb_data_cache_port0_arbiter.sv
// Self-checking bench for data_cache_port0_arbiter.
// Directed scenarios are followed by a randomized run. Every cycle is
// compared against a behavioural model that tracks the owner and the wait
// times as plain integers.
module tb_data_cache_port0_arbiter;

  localparam int LIMIT = 8;

  logic       clk;
  logic       rst;
  logic       inv_req;
  logic       stu_req;
  logic       ldu_req;
  logic [2:0] rel;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic [2:0] starved;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: owner index (-1 = none) and cycles waited per requester.
  int m_owner = -1;
  int m_wait[3] = '{0, 0, 0};

  data_cache_port0_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .inv_request_i (inv_req),
    .stu_request_i (stu_req),
    .ldu_request_i (ldu_req),
    .release_i     (rel),
    .grant_o       (grant),
    .port0_select_o(sel),
    .port0_busy_o  (busy),
    .starved_o     (starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
  endtask

  // One clock edge of the arbitration rules, using the sampled requests and releases.
  task automatic model_edge(input logic [2:0] req, input logic [2:0] r);
    int new_owner;
    new_owner = m_owner;
    if (m_owner >= 0) begin
      if (r[m_owner]) new_owner = -1;
    end else begin
      for (int i = 2; i >= 0; i--)
        if (req[i]) new_owner = i;
      for (int i = 2; i >= 0; i--)
        if (req[i] && m_wait[i] == LIMIT) new_owner = i;
    end
    for (int i = 0; i < 3; i++) begin
      if (!req[i] || i == m_owner || i == new_owner) m_wait[i] = 0;
      else if (m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
    end
    m_owner = new_owner;
  endtask

  // Compare every output against the model.
  task automatic check_all();
    logic [2:0] e_grant;
    logic [1:0] e_sel;
    logic [2:0] e_starved;
    e_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    e_sel   = (m_owner < 0) ? 2'b00 : 2'(m_owner + 1);
    for (int i = 0; i < 3; i++) e_starved[i] = (m_wait[i] == LIMIT);
    check("grant", 32'(grant), 32'(e_grant));
    check("select", 32'(sel), 32'(e_sel));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("starved", 32'(starved), 32'(e_starved));
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  // Drive {ldu,stu,inv} and release, take one edge, then check 1 time unit later.
  task automatic step(input logic [2:0] req, input logic [2:0] r);
    inv_req = req[0];
    stu_req = req[1];
    ldu_req = req[2];
    rel     = r;
    @(posedge clk);
    model_edge(req, r);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  int max_wait;
  int max_tenure;
  int cur_wait[3];
  int tenure;
  int grants;

  initial begin
    logic [2:0] req;
    logic [2:0] r;
    int prev_owner;
    rst = 1'b1;
    inv_req = 1'b0;
    stu_req = 1'b0;
    ldu_req = 1'b0;
    rel = 3'b000;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_starved", 32'(starved), 32'd0);
    apply_reset();

    // Single store-unit tenure with its request dropped while it holds the port.
    step(3'b010, 3'b000);
    check("s1_grant", 32'(grant), 32'b010);
    check("s1_sel", 32'(sel), 32'b10);
    check("s1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 5; k++) step(3'b000, 3'b000);
    check("s1_held", 32'(grant), 32'b010);
    step(3'b000, 3'b010);
    check("s1_release", 32'(grant), 32'b000);
    $display("txn: store tenure grant/hold/release");

    // All three requesters at once; each release is followed by one dead cycle.
    step(3'b111, 3'b000);
    check("s2_inv", 32'(grant), 32'b001);
    step(3'b110, 3'b001);
    check("s2_dead1", 32'(grant), 32'b000);
    step(3'b110, 3'b000);
    check("s2_stu", 32'(grant), 32'b010);
    step(3'b100, 3'b010);
    check("s2_dead2", 32'(grant), 32'b000);
    step(3'b100, 3'b000);
    check("s2_ldu", 32'(grant), 32'b100);
    step(3'b000, 3'b100);
    $display("txn: three-way fixed priority sequence");

    // Release bits from a non-owner, and releases while IDLE, have no effect.
    step(3'b010, 3'b000);
    step(3'b000, 3'b100);
    check("s3_foreign_rel", 32'(grant), 32'b010);
    step(3'b000, 3'b010);
    step(3'b000, 3'b111);
    check("s3_idle_rel", 32'(grant), 32'b000);
    $display("txn: ignored releases");

    // Starvation promotion: the load unit waits out the store unit's 10-cycle tenure.
    apply_reset();
    step(3'b110, 3'b000);
    for (int k = 0; k < 6; k++) step(3'b110, 3'b000);
    check("s4_not_yet", 32'(starved), 32'b000);
    step(3'b110, 3'b000);
    check("s4_starved", 32'(starved), 32'b100);
    step(3'b110, 3'b000);
    step(3'b110, 3'b000);
    step(3'b110, 3'b010);
    check("s4_dead", 32'(grant), 32'b000);
    step(3'b110, 3'b000);
    check("s4_ldu_wins", 32'(grant), 32'b100);
    check("s4_ldu_clear", 32'(starved[2]), 32'd0);
    $display("txn: starvation promotion of load unit");

    // An asynchronous reset in the middle of a tenure drops the grant without waiting for a clock edge.
    inv_req = 1'b1;
    stu_req = 1'b1;
    ldu_req = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("s5_async_grant", 32'(grant), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    check("s5_async_starved", 32'(starved), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(3'b111, 3'b000);
    check("s5_first_grant", 32'(grant), 32'b001);
    step(3'b000, 3'b001);
    $display("txn: async reset mid-tenure");

    // Randomized run checked every cycle against the model.
    apply_reset();
    max_wait = 0;
    max_tenure = 0;
    tenure = 0;
    grants = 0;
    for (int i = 0; i < 3; i++) cur_wait[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++) req[i] = ($urandom_range(0, 3) != 0);
      r = 3'($urandom & $urandom & 7);
      if (m_owner >= 0 && $urandom_range(0, 3) == 0) r[m_owner] = 1'b1;
      prev_owner = m_owner;
      step(req, r);
      if (m_owner >= 0 && prev_owner < 0) begin
        grants++;
        $display("txn %0d: cycle %0d grant to requester %0d", grants, c, m_owner);
      end
      tenure = (m_owner >= 0) ? tenure + 1 : 0;
      if (tenure > max_tenure) max_tenure = tenure;
      for (int i = 0; i < 3; i++) begin
        cur_wait[i] = (req[i] && m_owner != i) ? cur_wait[i] + 1 : 0;
        if (cur_wait[i] > max_wait) max_wait = cur_wait[i];
      end
    end
    $display("random run: %0d grants, longest wait %0d, longest tenure %0d", grants, max_wait, max_tenure);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
